// File: rtl/cone_capture_misr.sv
// Capture stage for an extracted combinational cone: feeds cone_out back as state_q,
// folds every captured value into a MISR and counts disagreements with a golden stream.
module cone_capture_misr #(
  parameter int                N_OUT  = 1,
  parameter int                MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY   = 16'h002D,
  parameter logic [MISR_W-1:0] SEED   = 16'hFFFF,
  parameter int                CNT_W  = 16
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_cycles,
  input  logic [N_OUT-1:0]  init_state,
  input  logic [N_OUT-1:0]  cone_out,
  input  logic [N_OUT-1:0]  gold_in,
  output logic [N_OUT-1:0]  state_q,
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] signature,
  output logic [7:0]        mismatch_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [N_OUT-1:0]  r_state_q;
  logic              r_busy;
  logic              r_done;
  logic [MISR_W-1:0] r_sig;
  logic [7:0]        r_mm;

  logic [MISR_W-1:0] w_cone_ext;
  logic [MISR_W-1:0] w_sig_next;

  // cone_out zero-extended into the low bits of the signature width
  always_comb begin
    w_cone_ext = '0;
    w_cone_ext[N_OUT-1:0] = cone_out;
  end

  assign w_sig_next = {r_sig[MISR_W-2:0], 1'b0}
                    ^ (r_sig[MISR_W-1] ? POLY : '0)
                    ^ w_cone_ext;

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_state_q <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sig     <= SEED;
      r_mm      <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state_q <= init_state;
            r_sig     <= SEED;
            r_mm      <= 8'd0;
            r_cnt     <= n_cycles;
            if (n_cycles != '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_state_q <= cone_out;
          r_sig     <= w_sig_next;
          if ((cone_out != gold_in) && (r_mm != 8'hFF))
            r_mm <= r_mm + 8'd1;
          // cnt is at least 1 in RUN, so the decrement never wraps
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign state_q      = r_state_q;
  assign busy         = r_busy;
  assign done         = r_done;
  assign signature    = r_sig;
  assign mismatch_cnt = r_mm;

endmodule

// File: doc/cone_capture_misr.md
# cone_capture_misr

Sequential capture stage placed directly downstream of an extracted combinational next-state cone, for example `s38584_n5895`. Each run cycle it registers the cone's partial output back as the cone's state input, which closes the loop that the combinational extraction opened. It also compresses every captured value into a MISR signature and counts cycles where the cone output disagrees with a golden reference stream. A start/done handshake runs a fixed number of cycles per session.

## Interface
Parameters:
- `N_OUT`, 1: number of cone outputs and fed-back state bits; must satisfy `N_OUT <= MISR_W`.
- `MISR_W`, 16: signature width.
- `POLY`, 16'h002D: MISR feedback polynomial taps (x^16+x^5+x^3+x^2+1).
- `SEED`, 16'hFFFF: signature value loaded at start.
- `CNT_W`, 16: width of the cycle-count input.

Ports:
- `CK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `start`  in  1  session request; sampled only in IDLE.
- `n_cycles`  in  CNT_W  number of capture cycles; sampled together with `start`.
- `init_state`  in  N_OUT  state value loaded into `state_q` at start.
- `cone_out`  in  N_OUT  cone output (e.g. n5895); combinational function of `state_q`.
- `gold_in`  in  N_OUT  golden expected value for `cone_out`, valid in RUN cycles.
- `state_q`  out  N_OUT  registered state fed back to the cone (e.g. g142).
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when the session ends.
- `signature`  out  MISR_W  MISR contents.
- `mismatch_cnt`  out  8  count of mismatching RUN cycles, saturating at 255.

## Operation
- FSM states are IDLE, RUN and DONE. Reset value is IDLE.
- Reset values of all outputs:
  - `state_q` = 0
  - `busy` = 0
  - `done` = 0
  - `signature` = SEED
  - `mismatch_cnt` = 0
- The internal counter `cnt` resets to 0.
- IDLE with `start`=1 and `n_cycles`!=0:
  - `state_q` <= `init_state`, `signature` <= SEED, `mismatch_cnt` <= 0, `cnt` <= `n_cycles`.
  - FSM goes to RUN.
- IDLE with `start`=1 and `n_cycles`==0: same loads as above, then the FSM goes straight to DONE with no capture.
- RUN, on every edge:
  - `state_q` <= `cone_out`.
  - `signature` <= (`signature` << 1) XOR (`signature`[MISR_W-1] ? POLY : 0) XOR zero-extended `cone_out`.
  - If `cone_out` != `gold_in` (any bit), `mismatch_cnt` increments; it saturates at 255.
  - `cnt` decrements. When `cnt`==1 on that edge, the FSM goes to DONE.
- DONE: `done`=1 for exactly one cycle, then the FSM returns to IDLE. `state_q`, `signature` and `mismatch_cnt` are unchanged in DONE.
- In IDLE, all registers hold their values. The signature stays readable until the next accepted start.
- `start` asserted in RUN or DONE is ignored; it is not queued.
- `gold_in` is ignored outside RUN.

## Timing
- `start` sampled at edge t with `n_cycles`=N>0:
  - `busy`=1 from after edge t through edge t+N.
  - Captures occur at edges t+1 through t+N.
  - `done`=1 in the cycle after edge t+N.
  - `busy` and `done` are never high together.
- With N=0, `done` is high in the cycle directly after edge t.
- Back-to-back sessions: a `start` held high through DONE is accepted at the first IDLE edge after DONE. The minimum spacing between accepted starts is therefore N+2 cycles.
- `RST` has priority over everything. Asserting it mid-RUN forces every register to its reset value on that edge, with no `done` pulse. `RST` asserted in the same cycle as `start` drops the start.
- `cnt` wrap: N = 2^CNT_W-1 is legal and runs exactly that many captures. `cnt` never underflows.

## Test plan
- Reset with MISR_W=16, then idle for 5 cycles -> `signature`=16'hFFFF, `mismatch_cnt`=0, `state_q`=0, `busy`=`done`=0 throughout.
- `start`, N=1, `cone_out` tied 0, `gold_in`=0 -> one capture; `signature`=16'hFFD3; `done` pulses exactly 2 cycles after the start edge; `mismatch_cnt`=0.
- Same as previous, but `cone_out` tied 1 and `gold_in`=0 -> `signature`=16'hFFD2, `mismatch_cnt`=1, `state_q`=1.
- `cone_out` driven as the inverse of `state_q`, `init_state`=0, N=4 -> `state_q` reads 1,0,1,0 after successive captures. Signature matches a software model. With `gold_in` always 0, `mismatch_cnt`=2.
- N=300 with `cone_out`!=`gold_in` every cycle -> `mismatch_cnt` saturates at 255. A `start` pulse mid-run is ignored, so exactly 300 captures occur.
- `RST` asserted at capture 3 of an N=10 run -> all outputs return to reset values on the next edge and no `done` pulse appears. A following N=0 start gives `done` one cycle later with `signature`=16'hFFFF.
